// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM states and address-register-file control codes for instruction fetch
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH_L, FETCH_H, DONE} state_t;
  localparam logic [2:0] FUN_INC     = 3'b001;
  localparam logic [2:0] FUN_NOP     = 3'b000;
  localparam logic [2:0] REGSEL_PC   = 3'b011;
  localparam logic [2:0] REGSEL_NONE = 3'b111;
  localparam logic [1:0] OUTSEL_PC   = 2'b00;
endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: two-byte little-endian fetch sequencer that advances PC through the register file
module instruction_fetch_unit
  import fetch_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        MemReady,
  input  logic [7:0]  MemData,
  output logic        MemRead,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_RegSel,
  output logic [2:0]  ARF_FunSel,
  output logic [15:0] IR,
  output logic        IRValid,
  output logic        Busy
);
  state_t     state;
  logic [7:0] hold;
  logic       accept;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      hold  <= '0;
      IR    <= '0;
    end else
      case (state)
        IDLE:    if (Start) state <= FETCH_L;
        FETCH_L: if (MemReady) begin
          hold  <= MemData;
          state <= FETCH_H;
        end
        FETCH_H: if (MemReady) begin
          IR    <= {MemData, hold};
          state <= DONE;
        end
        DONE:    state <= Start ? FETCH_L : IDLE;
        default: state <= IDLE;
      endcase
  // PC advances exactly on the cycles a byte is accepted, so it always points at the next byte
  always_comb begin
    Busy        = state == FETCH_L || state == FETCH_H;
    accept      = Busy && MemReady;
    MemRead     = Busy;
    IRValid     = state == DONE;
    ARF_OutDSel = OUTSEL_PC;
    ARF_RegSel  = accept ? REGSEL_PC : REGSEL_NONE;
    ARF_FunSel  = accept ? FUN_INC : FUN_NOP;
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with a PC/memory model standing in for the register file
module tb_instruction_fetch_unit;
  logic        clk = 0;
  logic        rst_n, start, mem_ready, mem_read, ir_valid, busy;
  logic [7:0]  mem_data;
  logic [1:0]  out_d_sel;
  logic [2:0]  reg_sel, fun_sel;
  logic [15:0] ir;
  logic [15:0] pc, pc_set;
  logic        pc_wr;
  logic [7:0]  mem [0:65535];
  logic [15:0] sb [$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .MemReady(mem_ready), .MemData(mem_data),
    .MemRead(mem_read), .ARF_OutDSel(out_d_sel), .ARF_RegSel(reg_sel), .ARF_FunSel(fun_sel),
    .IR(ir), .IRValid(ir_valid), .Busy(busy)
  );

  // register-file model: PC increments when the unit enables PC with the increment function
  assign mem_data = mem[pc];
  always @(posedge clk)
    if (pc_wr) pc <= pc_set;
    else if (reg_sel == 3'b011 && fun_sel == 3'b001) pc <= pc + 16'd1;

  function automatic logic inc_now();
    return reg_sel === 3'b011 && fun_sel === 3'b001;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_pc(input logic [15:0] v);
    pc_set = v;
    pc_wr = 1;
    tick();
    pc_wr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; mem_ready = 0; pc_wr = 0;
    tick(); tick();
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got %h exp 0000", ir); end
    checks++; if (ir_valid !== 1'b0 || busy !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got valid=%b busy=%b rd=%b exp 0 0 0", ir_valid, busy, mem_read); end
    checks++; if (reg_sel !== 3'b111 || fun_sel !== 3'b000 || out_d_sel !== 2'b00) begin
      errors++; $display("FAIL reset_arf got %b %b %b exp 111 000 00", reg_sel, fun_sel, out_d_sel); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_single_fetch();
    int incs = 0;
    load_pc(16'h0010);
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    sb.push_back(16'h1234);
    start = 1; mem_ready = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 0;
      #1;
      if (inc_now()) incs++;
      checks++; if (ir_valid !== (c == 3)) begin errors++; $display("FAIL single_valid c%0d got %b", c, ir_valid); end
      checks++; if (busy !== (c == 1 || c == 2)) begin errors++; $display("FAIL single_busy c%0d got %b", c, busy); end
      if (ir_valid) begin
        checks++; if (ir !== sb[0]) begin errors++; $display("FAIL single_ir got %h exp %h", ir, sb[0]); end
        sb.pop_front();
      end
    end
    checks++; if (incs != 2) begin errors++; $display("FAIL single_incs got %0d exp 2", incs); end
    checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL single_pc got %h exp 0012", pc); end
  endtask

  task automatic test_reset_mid_fetch();
    load_pc(16'h0060);
    mem[16'h0060] = 8'hEE; mem[16'h0061] = 8'hFF;
    start = 1; mem_ready = 1;
    tick(); start = 0;
    tick(); mem_ready = 0; #1;
    checks++; if (busy !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL mid_prefetch busy=%b exp 1", busy); end
    #2 rst_n = 0;
    #1;
    checks++; if (ir !== 16'h0000 || ir_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ir got %h valid=%b exp 0000 0", ir, ir_valid); end
    checks++; if (mem_read !== 1'b0 || busy !== 1'b0 || reg_sel !== 3'b111) begin
      errors++; $display("FAIL mid_reset_ctl got rd=%b busy=%b sel=%b exp 0 0 111", mem_read, busy, reg_sel); end
    tick(); rst_n = 1;
    tick(); #1;
    checks++; if (busy !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL mid_after busy=%b valid=%b", busy, ir_valid); end
    checks++; if (pc !== 16'h0061) begin errors++; $display("FAIL mid_pc got %h exp 0061", pc); end
  endtask

  task automatic test_wait_states();
    logic [15:0] ir0;
    logic [7:0]  rdy;
    rdy = 8'b0110_1000;
    load_pc(16'h0020);
    mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22;
    sb.push_back(16'h2211);
    ir0 = ir;
    start = 1; mem_ready = 0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 0;
      mem_ready = rdy[c];
      #1;
      checks++; if (ir_valid !== (c == 6)) begin errors++; $display("FAIL wait_valid c%0d got %b", c, ir_valid); end
      checks++; if (inc_now() !== (c == 3 || c == 5)) begin errors++; $display("FAIL wait_inc c%0d got %b", c, inc_now()); end
      if (c <= 5) begin
        checks++; if (ir !== ir0) begin errors++; $display("FAIL wait_ir_hold c%0d got %h exp %h", c, ir, ir0); end
      end
      if (ir_valid) begin
        checks++; if (ir !== sb[0]) begin errors++; $display("FAIL wait_ir got %h exp %h", ir, sb[0]); end
        sb.pop_front();
      end
    end
    checks++; if (pc !== 16'h0022) begin errors++; $display("FAIL wait_pc got %h exp 0022", pc); end
  endtask

  task automatic test_back_to_back();
    load_pc(16'h0040);
    mem[16'h0040] = 8'hAA; mem[16'h0041] = 8'hBB; mem[16'h0042] = 8'hCC; mem[16'h0043] = 8'hDD;
    sb.push_back(16'hBBAA); sb.push_back(16'hDDCC);
    start = 1; mem_ready = 1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 4) start = 0;
      #1;
      checks++; if (ir_valid !== (c == 3 || c == 6)) begin errors++; $display("FAIL b2b_valid c%0d got %b", c, ir_valid); end
      checks++; if (busy !== (c != 3 && c != 6 && c != 7)) begin errors++; $display("FAIL b2b_busy c%0d got %b", c, busy); end
      if (ir_valid) begin
        checks++; if (ir !== sb[0]) begin errors++; $display("FAIL b2b_ir c%0d got %h exp %h", c, ir, sb[0]); end
        sb.pop_front();
      end
    end
    checks++; if (pc !== 16'h0044) begin errors++; $display("FAIL b2b_pc got %h exp 0044", pc); end
  endtask

  task automatic test_wrap();
    load_pc(16'hFFFF);
    mem[16'hFFFF] = 8'h78; mem[16'h0000] = 8'h56;
    sb.push_back(16'h5678);
    start = 1; mem_ready = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 0;
      #1;
      checks++; if (ir_valid !== (c == 3)) begin errors++; $display("FAIL wrap_valid c%0d got %b", c, ir_valid); end
      if (ir_valid) begin
        checks++; if (ir !== sb[0]) begin errors++; $display("FAIL wrap_ir got %h exp %h", ir, sb[0]); end
        sb.pop_front();
      end
    end
    checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL wrap_pc got %h exp 0001", pc); end
  endtask

  task automatic test_start_ignored();
    load_pc(16'h0050);
    mem[16'h0050] = 8'hBC; mem[16'h0051] = 8'h9A;
    sb.push_back(16'h9ABC);
    start = 1; mem_ready = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = (c == 1 || c == 2) ? ~start : 1'b0;
      #1;
      checks++; if (ir_valid !== (c == 3)) begin errors++; $display("FAIL toggle_valid c%0d got %b", c, ir_valid); end
      checks++; if (busy !== (c == 1 || c == 2)) begin errors++; $display("FAIL toggle_busy c%0d got %b", c, busy); end
      if (ir_valid) begin
        checks++; if (ir !== sb[0]) begin errors++; $display("FAIL toggle_ir got %h exp %h", ir, sb[0]); end
        sb.pop_front();
      end
    end
    checks++; if (pc !== 16'h0052) begin errors++; $display("FAIL toggle_pc got %h exp 0052", pc); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_reset_mid_fetch();
    test_wait_states();
    test_back_to_back();
    test_wrap();
    test_start_ignored();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Two-byte instruction fetch sequencer upstream of the address register file. On request it drives the file's PC-select and PC-increment controls and reads two bytes from 8-bit memory at the current PC, then the next PC. It assembles them little-endian into a 16-bit instruction register and flags it valid for one cycle. It is the only block that advances PC during fetch.

## Interface

- No parameters (widths fixed by the datapath: 16-bit address/instruction, 8-bit memory).
- Clock  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-low; clears all state when 0.
- Start  in  1  fetch request, sampled in IDLE and DONE only.
- MemReady  in  1  memory has valid data on MemData this cycle.
- MemData  in  8  byte read from the address on ARF OutD.
- MemRead  out  1  memory read enable.
- ARF_OutDSel  out  2  to address register file OutDSel; constant 2'b00 (PC).
- ARF_RegSel  out  3  to address register file RegSel; active-low enables, bit2=PC, bit1=AR, bit0=SP.
- ARF_FunSel  out  3  to address register file FunSel.
- IR  out  16  instruction register; {high byte, low byte}.
- IRValid  out  1  one-cycle pulse: IR has just been loaded.
- Busy  out  1  fetch in progress (FETCH_L or FETCH_H).

## Operation

- FSM states: IDLE, FETCH_L, FETCH_H, DONE; all state is held in flops cleared by Reset.
- IDLE: Start=1 goes to FETCH_L; otherwise stays in IDLE.
- FETCH_L: MemRead=1.
  - MemReady=1: MemData is captured into an internal low-byte holding register, PC is incremented in the same cycle, and the FSM goes to FETCH_H.
  - MemReady=0: the FSM stays in FETCH_L and PC is untouched.
- FETCH_H: MemRead=1.
  - MemReady=1: IR loads {MemData, holding byte} in one shot, PC is incremented, and the FSM goes to DONE.
  - MemReady=0: the FSM waits.
- DONE: IRValid=1. Start=1 goes to FETCH_L (back-to-back fetch); otherwise the FSM goes to IDLE.
- PC increment: ARF_RegSel=3'b011 (PC only) and ARF_FunSel=FUN_INC (3'b001), asserted only in the accept cycle, i.e. FETCH_x with MemReady=1.
- All other cycles: ARF_RegSel=3'b111 (no register enabled) and ARF_FunSel=3'b000.
- IR never shows a mixed old/new value; it changes only on the FETCH_H accept edge.
- Start during FETCH_L/FETCH_H is ignored, not queued.
- PC wrap-around (16'hFFFF to 16'h0000) is owned by the register file. The unit is oblivious to it and fetches the high byte from 0x0000.

## Timing

- Reset (asynchronous assert, any state, including mid-fetch):
  - State=IDLE, IR=16'h0000, holding byte=8'h00, IRValid=0, Busy=0, MemRead=0, ARF_RegSel=3'b111, ARF_FunSel=3'b000, ARF_OutDSel=2'b00.
  - A half-fetched instruction is discarded; the PC increment already applied is not undone.
- MemRead, ARF_RegSel, ARF_FunSel and Busy are combinational from state and MemReady; no added latency.
- IRValid is decoded from the state register (Moore); IR is registered.
- With MemReady held at 1: Start sampled high at edge 0 gives FETCH_L in cycle 1, FETCH_H in cycle 2, and DONE (IRValid=1) in cycle 3. IR is valid from edge 3.
- Each MemReady=0 cycle in a fetch state adds exactly one cycle.
- Back-to-back throughput: one instruction per 3 cycles (DONE to FETCH_L).
- Memory is combinational-read: data for the address on OutD is expected on MemData in the same cycle as MemReady.

## Structure

- Shared package fetch_pkg:
  - FSM state enum.
  - FUN_INC=3'b001, FUN_NOP=3'b000.
  - REGSEL_PC=3'b011, REGSEL_NONE=3'b111.
  - OUTSEL_PC=2'b00.
- No sub-module: FSM, holding byte and IR are local. The generic Register is not reused because IR needs a single 16-bit parallel load.

## Test plan

- Reset mid-fetch: assert Reset=0 in FETCH_H -> IDLE, IR=0, IRValid=0, MemRead=0, RegSel=3'b111 immediately, without waiting for a clock edge.
- Single fetch, PC=0x0010, mem[0x10]=0x34, mem[0x11]=0x12, MemReady=1 -> IR=0x1234, IRValid pulses in cycle 3, PC=0x0012, RegSel=3'b011 in exactly two cycles.
- Wait states: MemReady low for 2 cycles in FETCH_L and 1 cycle in FETCH_H -> IRValid in cycle 6, PC increments only in accept cycles, IR unchanged until the FETCH_H accept.
- Back-to-back: Start held high, memory 0xAA,0xBB,0xCC,0xDD -> IR=0xBBAA, then IR=0xDDCC three cycles later, IRValid pulses separated by 2 low cycles.
- Wrap: PC=0xFFFF, mem[0xFFFF]=0x78, mem[0x0000]=0x56 -> IR=0x5678, PC=0x0001.
- Start toggled during FETCH_L/FETCH_H -> no extra fetch; the FSM returns to IDLE after DONE if Start=0 there.
